// File: rtl/bscan_dr_endpoint.sv
// rtl/bscan_dr_endpoint.sv - BSCAN USER DR endpoint: tdi frame deserializer into a FIFO, result serializer on tdo
module bscan_dr_endpoint #(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 tck,
  input  logic                 test_logic_reset,
  input  logic                 ir_is_user,
  input  logic                 capture_dr,
  input  logic                 shift_dr,
  input  logic                 update_dr,
  input  logic                 tdi,
  output logic                 tdo,
  input  logic [OUT_WIDTH-1:0] result,
  output logic [IN_WIDTH-1:0]  out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(OUT_WIDTH + 2);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FRAME = IN_WIDTH[CNT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(OUT_WIDTH + 1);
  localparam logic [PTR_W:0]   FULL_CNT  = FIFO_DEPTH[PTR_W:0];

  logic [IN_WIDTH-1:0]  rx_shift;
  logic [OUT_WIDTH-1:0] tx_shift;
  logic [CNT_W-1:0]     bit_cnt;

  logic [IN_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;

  logic full;
  logic pop;
  logic push_req;
  logic push_ok;

  assign tdo       = tx_shift[0];
  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // Only an exact IN_WIDTH-bit shift is an inbound frame; readbacks and partials are ignored.
  assign push_req  = ir_is_user & update_dr & (bit_cnt == CNT_FRAME);
  assign push_ok   = push_req & (~full | pop);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge tck) begin
    if (test_logic_reset) begin
      rx_shift <= '0;
      tx_shift <= '0;
      bit_cnt  <= '0;
    end else if (ir_is_user) begin
      if (capture_dr) begin
        tx_shift <= result;
        bit_cnt  <= '0;
      end else if (shift_dr) begin
        rx_shift <= {tdi, rx_shift[IN_WIDTH-1:1]};
        tx_shift <= {tdi, tx_shift[OUT_WIDTH-1:1]};
        // Saturate past OUT_WIDTH so a long shift never wraps back onto IN_WIDTH.
        if (bit_cnt != CNT_SAT) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge tck) begin
    if (!test_logic_reset && push_ok) begin
      mem[wr_ptr] <= rx_shift;
    end
  end

  always_ff @(posedge tck) begin
    if (test_logic_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bscan_dr_endpoint.sv
// tb/tb_bscan_dr_endpoint.sv - directed scoreboard bench for bscan_dr_endpoint
module tb_bscan_dr_endpoint;

  logic        tck = 1'b0;
  logic        test_logic_reset;
  logic        ir_is_user;
  logic        capture_dr;
  logic        shift_dr;
  logic        update_dr;
  logic        tdi;
  logic        tdo;
  logic [15:0] result;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;

  int passed = 0;
  int total  = 0;
  logic [7:0] sb[$];

  bscan_dr_endpoint #(.IN_WIDTH(8), .OUT_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .tck(tck),
    .test_logic_reset(test_logic_reset),
    .ir_is_user(ir_is_user),
    .capture_dr(capture_dr),
    .shift_dr(shift_dr),
    .update_dr(update_dr),
    .tdi(tdi),
    .tdo(tdo),
    .result(result),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overflow(overflow)
  );

  always #5 tck = ~tck;

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, 32'(out_data), 32'(e));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] v, input int n, input logic user, input logic pop_upd);
    logic [2:0] idx;
    logic [7:0] e;
    ir_is_user = user;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr   = 1'b1;
    for (int i = 0; i < n; i++) begin
      idx = i[2:0];
      tdi = (i < 8) ? v[idx] : 1'b0;
      tick();
    end
    shift_dr  = 1'b0;
    tdi       = 1'b0;
    update_dr = 1'b1;
    if (pop_upd) begin
      chk("pop_on_update_sb", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pop_on_update_data", 32'(out_data), 32'(e));
      end
      out_ready = 1'b1;
    end
    tick();
    update_dr  = 1'b0;
    out_ready  = 1'b0;
    ir_is_user = 1'b0;
  endtask

  initial begin
    logic [15:0] rb;
    logic [7:0]  burst [4];
    logic [3:0]  k4;
    burst[0] = 8'h52; burst[1] = 8'h34; burst[2] = 8'h38; burst[3] = 8'h0A;

    test_logic_reset = 1'b1;
    ir_is_user = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
    tdi = 1'b0; result = 16'h0000; out_ready = 1'b0;
    tick(); tick();
    test_logic_reset = 1'b0;
    chk("rst_tdo", 32'(tdo), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // single 'L' frame, held then popped
    send_frame(8'h4C, 8, 1'b1, 1'b0);
    sb.push_back(8'h4C);
    tick();
    chk("L_held_valid", 32'(out_valid), 32'd1);
    pop_one("L");
    chk("L_empty", 32'(out_valid), 32'd0);

    // 16-bit readback
    rb = 16'h0403;
    result = rb;
    ir_is_user = 1'b1;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr = 1'b1;
    tdi = 1'b0;
    for (int k = 0; k < 16; k++) begin
      k4 = k[3:0];
      chk($sformatf("rb_tdo_%0d", k), 32'(tdo), 32'(rb[k4]));
      tick();
    end
    shift_dr = 1'b0;
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    ir_is_user = 1'b0;
    chk("rb_no_push", 32'(out_valid), 32'd0);

    // wrong-length frames
    send_frame(8'hA5, 7, 1'b1, 1'b0);
    send_frame(8'hA5, 9, 1'b1, 1'b0);
    chk("len_no_push", 32'(out_valid), 32'd0);
    chk("len_no_ovf", 32'(overflow), 32'd0);

    // fill, overflow, drain
    for (int i = 0; i < 4; i++) begin
      send_frame(burst[i], 8, 1'b1, 1'b0);
      sb.push_back(burst[i]);
    end
    chk("full_no_ovf", 32'(overflow), 32'd0);
    send_frame(8'h4C, 8, 1'b1, 1'b0);
    chk("full_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) pop_one($sformatf("drain1_%0d", i));
    chk("drain1_empty", 32'(out_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    test_logic_reset = 1'b1;
    tick();
    test_logic_reset = 1'b0;
    chk("rst2_ovf", 32'(overflow), 32'd0);

    // full with a same-cycle pop accepts the push
    for (int i = 0; i < 4; i++) begin
      send_frame(burst[i], 8, 1'b1, 1'b0);
      sb.push_back(burst[i]);
    end
    send_frame(8'h35, 8, 1'b1, 1'b1);
    sb.push_back(8'h35);
    chk("fullpop_no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) pop_one($sformatf("drain2_%0d", i));
    chk("drain2_empty", 32'(out_valid), 32'd0);

    // reset mid-shift discards the partial frame
    result = 16'hFFFF;
    ir_is_user = 1'b1;
    capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    shift_dr = 1'b1;
    tdi = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    test_logic_reset = 1'b1;
    tick();
    test_logic_reset = 1'b0;
    chk("midrst_tdo", 32'(tdo), 32'd0);
    tdi = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    shift_dr = 1'b0;
    update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    ir_is_user = 1'b0;
    chk("midrst_no_push", 32'(out_valid), 32'd0);
    chk("midrst_no_ovf", 32'(overflow), 32'd0);

    // non-USER instruction: whole frame ignored
    send_frame(8'h4C, 8, 1'b0, 1'b0);
    chk("nouser_no_push", 32'(out_valid), 32'd0);
    chk("nouser_tdo", 32'(tdo), 32'd0);
    chk("nouser_no_ovf", 32'(overflow), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bscan_dr_endpoint.md
Name: bscan_dr_endpoint

Overview:
- User-side endpoint of the BSCAN USER data register; the responder the host-side JTAG driver talks to.
- Deserializes IN_WIDTH-bit frames shifted in on tdi, LSB first, and queues them in a small FIFO for the puzzle datapath, which reads it with a valid/ready handshake.
- On capture_dr, loads an OUT_WIDTH-bit result from the datapath and serializes it on tdo, LSB first.
- Sits between the BSCAN primitive signals and the solver core, all in the tck domain.

Parameters:
IN_WIDTH, 8, bits per inbound frame (one ASCII byte).
OUT_WIDTH, 16, bits per readback frame.
FIFO_DEPTH, 4, inbound frame queue entries (power of two, >= 2).

Ports:
tck  input  1  JTAG clock; all logic on rising edge.
test_logic_reset  input  1  synchronous active-high reset.
ir_is_user  input  1  USER instruction selected; gates capture/shift/update.
capture_dr  input  1  TAP in capture-DR.
shift_dr  input  1  TAP in shift-DR.
update_dr  input  1  TAP in update-DR.
tdi  input  1  serial data in.
tdo  output  1  serial data out (tx_shift[0]).
result  input  OUT_WIDTH  value to read back.
out_data  output  IN_WIDTH  FIFO head frame.
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts head.
overflow  output  1  sticky: frame dropped because FIFO full.

Behaviour:
- Reset (test_logic_reset=1 at the edge): rx_shift=0, tx_shift=0, bit_cnt=0, FIFO emptied, overflow=0. Resulting outputs: tdo=0, out_valid=0, out_data=0. Reset wins over every other input, including a reset mid-shift: the partial frame is discarded.
- Gating: when ir_is_user=0, capture_dr, shift_dr and update_dr are ignored. The FIFO pop side keeps operating.
- capture_dr:
  - tx_shift <= result.
  - bit_cnt <= 0.
  - rx_shift is unchanged.
- shift_dr, per edge:
  - rx_shift <= {tdi, rx_shift[IN_WIDTH-1:1]}.
  - tx_shift <= {tdi, tx_shift[OUT_WIDTH-1:1]}.
  - bit_cnt increments, saturating at OUT_WIDTH+1, so a long shift can never alias to IN_WIDTH.
- tdo is combinational from tx_shift[0]. After the capture edge, tdo = result[0] before the first shift edge; after k shift edges, tdo = result[k].
- update_dr:
  - If bit_cnt == IN_WIDTH, push rx_shift into the FIFO.
  - Any other count (0, partial, 16-bit readback, saturated) pushes nothing and raises no flag.
  - An 8-bit frame sent LSB first lands in rx_shift with its natural bit order.
- Push latency: out_valid is 1 and out_data valid after the update_dr edge (1 cycle).
- Pop: on an edge where out_valid & out_ready, the head advances. out_data is a registered or RAM-read head with no bubble: back-to-back pops are allowed every cycle.
- Full:
  - A push while full with no pop in the same cycle drops the frame, sets overflow, and leaves the FIFO unchanged.
  - A push while full with a pop in the same cycle is accepted; occupancy is unchanged.
- Empty: a pop with out_valid=0 is ignored. A push and a pop in the same cycle on an empty FIFO: push accepted, nothing popped.
- overflow clears only on reset.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter width is clog2(FIFO_DEPTH)+1.

Test Plan:
- Shift 0x4C ('L') LSB first (capture, 8 shifts, update), out_ready=0 -> out_valid=1 the cycle after the update edge, out_data=0x4C; raise out_ready for 1 cycle -> out_valid=0.
- result=0x0403; capture, then 16 shifts with tdi=0 -> tdo sampled before each edge = 1,1,0,0,0,0,0,0,0,0,1,0,0,0,0,0; update pushes nothing (bit_cnt=16).
- Frame with 7 shifts, then frame with 9 shifts, each followed by update -> out_valid stays 0, overflow=0.
- out_ready=0; send 'R','4','8','\n' (0x52,0x34,0x38,0x0A), then 'L' -> overflow=1; pops return 0x52,0x34,0x38,0x0A, then out_valid=0.
- FIFO full, out_ready=1 on the update edge of a 5th frame 0x35 -> no overflow; drain yields 0x34,0x38,0x0A,0x35.
- Assert reset after 4 shift edges of a frame, and separately with ir_is_user=0 during a full 8-bit frame -> FIFO stays empty, tdo=0 after reset, overflow=0.
